// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared defaults and types for the scoreboarded register file.
//               RF_WIDTH / RF_DEPTH / RF_ADDR_W : default geometry
//               RF_RESET_VALUE                  : default reset contents
//               word_t / addr_t                 : data word and address types
// Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_WIDTH  = 8;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = $clog2(RF_DEPTH);

  typedef logic [RF_WIDTH-1:0]  word_t;
  typedef logic [RF_ADDR_W-1:0] addr_t;

  localparam word_t RF_RESET_VALUE = {RF_WIDTH{1'b1}};

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One asynchronous read port of the register file: selects the
//               addressed word and its busy bit.
//               Optional macro WRITE_BYPASS_EN: when defined, a same-cycle
//               write-back to the addressed register is forwarded (wb_data,
//               busy reported as 0). When undefined, only stored state is
//               returned and a write becomes visible on the next cycle.
// Ports       : regs_i      stored words
//               busy_i      stored busy vector
//               rd_addr_i   read address
//               wb_en_i / wb_addr_i / wb_data_i  write-back bus (bypass only)
//               rd_data_o   read data
//               rd_busy_o   busy bit of the read address
// Revision    : 1.0  initial release
// ============================================================================
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0]  regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_busy_o
);

`ifdef WRITE_BYPASS_EN
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    // The write-back clears busy, so a forwarded value is never busy, even if
    // a new issue to the same register is accepted in this cycle.
    if (wb_en_i && (rd_addr_i == wb_addr_i)) begin
      rd_data_o = wb_data_i;
      rd_busy_o = 1'b0;
    end
  end
`else
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
  end

  // Write-back bus only feeds the bypass path.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{wb_en_i, wb_addr_i, wb_data_i};
`endif

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scoreboard
// Description : Flip-flop register file with two asynchronous read ports, one
//               synchronous write-back port and a per-register busy
//               scoreboard (set at issue, cleared at write-back), plus a
//               registered count of busy registers.
//               Optional macro WRITE_BYPASS_EN enables write-back forwarding
//               on the read ports (see rf_read_port).
// Ports       : clk                      rising-edge clock
//               reset                    synchronous, active-low
//               rd_addr_a/rd_data_a/rd_busy_a   read port A
//               rd_addr_b/rd_data_b/rd_busy_b   read port B
//               issue_en/issue_dst       mark a destination busy
//               issue_stall              issue refused this cycle
//               wb_en/wb_addr/wb_data    write-back
//               busy_count               registered number of busy registers
// Revision    : 1.0  initial release
// ============================================================================
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int               WIDTH       = RF_WIDTH,
  parameter int               DEPTH       = RF_DEPTH,
  parameter int               ADDR_W      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [ADDR_W:0]   busy_count
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [ADDR_W:0]  busy_count_q;
  logic [ADDR_W:0]  busy_count_d;

  // A busy destination may still be issued when its write-back lands in the
  // same cycle: ownership passes straight to the new issuer.
  assign issue_stall = issue_en && busy_q[issue_dst] &&
                       !(wb_en && (wb_addr == issue_dst));

  // Write-back clears first so a same-address issue ends with busy set.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue_en && !issue_stall) begin
      busy_d[issue_dst] = 1'b1;
    end
  end

  // Count is taken from the next busy vector so the registered value always
  // matches the busy bits it sits beside.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (wb_en) begin
        regs_q[wb_addr] <= wb_data;
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  rf_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .rd_addr_i (rd_addr_a),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .rd_data_o (rd_data_a),
    .rd_busy_o (rd_busy_a)
  );

  rf_read_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .rd_addr_i (rd_addr_b),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .rd_data_o (rd_data_b),
    .rd_busy_o (rd_busy_b)
  );

endmodule : reg_file_scoreboard
`default_nettype wire
